// File: rtl/block_word_reader_if.sv
// rtl/block_word_reader_if.sv - word stream from block_word_reader to the message-schedule stage
interface block_word_reader_if;
    logic [31:0] word;
    logic        word_valid;
    logic        word_ready;
    logic [3:0]  word_idx;
    logic        last_word;

    modport master (
        output word,
        output word_valid,
        output word_idx,
        output last_word,
        input  word_ready
    );

    modport slave (
        input  word,
        input  word_valid,
        input  word_idx,
        input  last_word,
        output word_ready
    );
endinterface

// File: rtl/block_word_reader.sv
// rtl/block_word_reader.sv - sequences message-memory reads and packs bytes into big-endian 32-bit words
module block_word_reader #(
    parameter int DATA_DEPTH = 512,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            out_mem,
    output logic [ADDR_WIDTH-1:0] indirizzo_read,
    output logic [1:0]            state,
    block_word_reader_if.master   wr,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LAST,
        S_WAIT_OUT,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [1:0]            r_byte_cnt;
    logic [23:0]           r_sr;
    logic [31:0]           r_word;
    logic [3:0]            r_word_idx;
    logic                  r_word_last;
    logic                  w_handshake;

    assign w_handshake = (r_state == S_WAIT_OUT) && wr.word_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (start) w_next = S_FETCH;
            S_FETCH:    if (r_byte_cnt == 2'd3) w_next = S_LAST;
            S_LAST:     w_next = S_WAIT_OUT;
            S_WAIT_OUT: if (w_handshake) w_next = r_word_last ? S_DONE : S_FETCH;
            S_DONE:     if (start) w_next = S_FETCH;
            default:    w_next = S_IDLE;
        endcase
    end

    // r_rd_addr remembers the last issued address so the read port holds still under backpressure.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_addr      <= '0;
            r_rd_addr   <= '0;
            r_byte_cnt  <= '0;
            r_sr        <= '0;
            r_word      <= '0;
            r_word_idx  <= '0;
            r_word_last <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_addr     <= '0;
                        r_byte_cnt <= '0;
                    end
                end
                S_FETCH: begin
                    r_rd_addr  <= r_addr;
                    r_addr     <= r_addr + ADDR_WIDTH'(1);
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                    r_sr       <= {r_sr[15:0], out_mem};
                end
                S_LAST: begin
                    r_word      <= {r_sr, out_mem};
                    r_word_idx  <= r_rd_addr[5:2];
                    r_word_last <= &r_rd_addr[ADDR_WIDTH-1:2];
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state          = 2'b00;
        indirizzo_read = r_rd_addr;
        busy           = 1'b0;
        done           = 1'b0;
        case (r_state)
            S_FETCH: begin
                state          = 2'b10;
                indirizzo_read = r_addr;
                busy           = 1'b1;
            end
            S_LAST, S_WAIT_OUT: busy = 1'b1;
            S_DONE:             done = 1'b1;
            default: begin
            end
        endcase
    end

    assign wr.word       = r_word;
    assign wr.word_idx   = r_word_idx;
    assign wr.word_valid = (r_state == S_WAIT_OUT);
    assign wr.last_word  = (r_state == S_WAIT_OUT) && (r_word_idx == 4'd15);

endmodule

// File: tb/tb_block_word_reader.sv
// tb/tb_block_word_reader.sv - directed self-checking bench for block_word_reader
module tb_block_word_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_a;
    logic       start_b;
    logic [7:0] mem_a;
    logic [7:0] mem_b;
    logic [8:0] addr_a;
    logic [5:0] addr_b;
    logic [1:0] rd_a;
    logic [1:0] rd_b;
    logic       busy_a, busy_b, done_a, done_b;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;

    block_word_reader_if a_if ();
    block_word_reader_if b_if ();

    block_word_reader #(.DATA_DEPTH(512), .ADDR_WIDTH(9)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .out_mem(mem_a),
        .indirizzo_read(addr_a), .state(rd_a), .wr(a_if), .busy(busy_a), .done(done_a)
    );

    block_word_reader #(.DATA_DEPTH(64), .ADDR_WIDTH(6)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .out_mem(mem_b),
        .indirizzo_read(addr_b), .state(rd_b), .wr(b_if), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    // Memories hold ram[i] = i[7:0] and register their read data.
    always @(posedge clk) begin
        if (rd_a == 2'b10) mem_a <= addr_a[7:0];
        if (rd_b == 2'b10) mem_b <= {2'b00, addr_b};
    end

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int n);
        logic [31:0] w;
        logic [31:0] b;
        w = '0;
        for (int j = 0; j < 4; j++) begin
            b = 32'(4 * n + j);
            w = {w[23:0], b[7:0]};
        end
        return w;
    endfunction

    task automatic chk_idle_a(input string tag);
        chk({tag, "_addr"}, 32'(addr_a), 0);
        chk({tag, "_rd"}, 32'(rd_a), 0);
        chk({tag, "_word"}, a_if.word, 0);
        chk({tag, "_valid"}, 32'(a_if.word_valid), 0);
        chk({tag, "_idx"}, 32'(a_if.word_idx), 0);
        chk({tag, "_last"}, 32'(a_if.last_word), 0);
        chk({tag, "_busy"}, 32'(busy_a), 0);
        chk({tag, "_done"}, 32'(done_a), 0);
    endtask

    task automatic pass_a(input int stall_word, input int stall_len, input int glitch_off,
                          input int exp_done_off);
        int   s;
        int   n;
        int   stall_left;
        logic got_done;
        s = cyc;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("pass_first_rd", 32'(rd_a), 32'h2);
        chk("pass_first_addr", 32'(addr_a), 0);
        chk("pass_done_cleared", 32'(done_a), 0);
        n = 0;
        stall_left = stall_len;
        got_done = 1'b0;
        for (int k = 0; k < 2000 && !got_done; k++) begin
            start_a = (cyc == s + glitch_off);
            a_if.word_ready = 1'b1;
            if (a_if.word_valid) begin
                chk("word", a_if.word, exp_word(n));
                chk("word_idx", 32'(a_if.word_idx), 32'(n % 16));
                chk("last_word", 32'(a_if.last_word), 32'(n % 16 == 15));
                if (n == 0) chk("word0", a_if.word, 32'h00010203);
                if (n == 15) chk("word15", a_if.word, 32'h3C3D3E3F);
                if (n == 16) chk("word16", a_if.word, 32'h40414243);
                if (n == 127) chk("word127", a_if.word, 32'hFCFDFEFF);
                if (n == stall_word && stall_left > 0) begin
                    a_if.word_ready = 1'b0;
                    stall_left--;
                    chk("stall_word", a_if.word, 32'h08090A0B);
                    chk("stall_rd", 32'(rd_a), 0);
                    chk("stall_addr", 32'(addr_a), 32'd11);
                end else begin
                    n++;
                end
            end
            if (done_a) begin
                got_done = 1'b1;
                chk("done_cycle", 32'(cyc - s), 32'(exp_done_off));
                chk("handshakes", 32'(n), 128);
                chk("busy_at_done", 32'(busy_a), 0);
            end else begin
                tick();
            end
        end
        start_a = 1'b0;
        chk("done_seen", 32'(got_done), 1);
    endtask

    task automatic pass_b;
        int   s;
        int   n;
        logic got_done;
        s = cyc;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n = 0;
        got_done = 1'b0;
        for (int k = 0; k < 500 && !got_done; k++) begin
            if (b_if.word_valid) begin
                chk("b_word", b_if.word, exp_word(n));
                chk("b_last_word", 32'(b_if.last_word), 32'(n == 15));
                n++;
            end
            if (done_b) begin
                got_done = 1'b1;
                chk("b_done_cycle", 32'(cyc - s), 32'd97);
                chk("b_words", 32'(n), 16);
            end else begin
                tick();
            end
        end
        chk("b_done_seen", 32'(got_done), 1);
    endtask

    task automatic reset_mid_pass;
        int n;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        a_if.word_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 200; k++) begin
            if (a_if.word_valid) begin
                if (n == 5) break;
                n++;
            end
            tick();
        end
        chk("rst_reach_word5", 32'(n), 5);
        chk("rst_word5", a_if.word, 32'h14151617);
        a_if.word_ready = 1'b0;
        tick();
        chk("rst_word5_held", 32'(a_if.word_valid), 1);
        reset = 1'b0;
        tick();
        chk("rst_mid_valid", 32'(a_if.word_valid), 0);
        chk("rst_mid_busy", 32'(busy_a), 0);
        chk("rst_mid_addr", 32'(addr_a), 0);
        chk("rst_mid_rd", 32'(rd_a), 0);
        reset = 1'b1;
        a_if.word_ready = 1'b1;
        tick();
        chk("rst_after_busy", 32'(busy_a), 0);
    endtask

    initial begin
        reset = 1'b0;
        start_a = 1'b1;
        start_b = 1'b1;
        a_if.word_ready = 1'b1;
        b_if.word_ready = 1'b1;
        tick();
        chk_idle_a("reset1");
        tick();
        chk_idle_a("reset2");
        chk("reset_b_rd", 32'(rd_b), 0);
        chk("reset_b_busy", 32'(busy_b), 0);
        reset = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        tick();
        chk_idle_a("idle");

        pass_a(-1, 0, -1, 769);
        pass_a(2, 10, -1, 779);
        pass_a(-1, 0, 20, 769);
        pass_a(-1, 0, -1, 769);
        reset_mid_pass();
        pass_a(-1, 0, -1, 769);
        pass_b();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/block_word_reader.md
# block_word_reader

Downstream consumer of the 512-byte message memory in the mining datapath. After the memory has been filled, it sequences the memory read port (`indirizzo_read`, `state`), collects the returned bytes and packs them big-endian into 32-bit words. Words go out over a valid/ready handshake to the SHA-256 message-schedule stage, tagged with their position inside the current 64-byte block. It raises `done` once the last byte of the memory has been delivered.

## Interface

Parameters:
- `DATA_DEPTH`, 512: bytes in memory. Must be a multiple of 64.
- `ADDR_WIDTH`, 9: width of `indirizzo_read`. Must equal log2(DATA_DEPTH).

Ports:
- `clk`  in  1  single clock; every register is updated on its rising edge.
- `reset`  in  1  synchronous reset, active-low. `reset`=0 at a rising edge resets the block.
- `start`  in  1  single-cycle pulse that starts a pass from address 0. Honoured only in IDLE or DONE.
- `out_mem`  in  8  read data from the memory. It is registered there, so it is valid the cycle after an address is issued with `state`=2'b10.
- `indirizzo_read`  out  ADDR_WIDTH  memory read address.
- `state`  out  2  memory read command. 2'b10 means issue a read; 2'b00 means idle.
- `word`  out  32  packed word. The lowest-address byte is in [31:24].
- `word_valid`  out  1  `word` is valid.
- `word_ready`  in  1  consumer accepts the word.
- `word_idx`  out  4  index of the word within its 64-byte block, 0..15.
- `last_word`  out  1  high when `word_idx`==15 and `word_valid`=1.
- `busy`  out  1  high in FETCH, LAST and WAIT_OUT.
- `done`  out  1  pass complete. Stays high until `start` or reset.

## Operation

- FSM states:
  - **IDLE.** On `start`=1, go to FETCH and clear `addr` and `byte_cnt`.
  - **FETCH.** Drive `indirizzo_read`=`addr` and `state`=2'b10 for 4 consecutive cycles, incrementing `addr` each cycle. Each byte returned by the memory is shifted in: `sr` <= {`sr`[23:0], `out_mem`}. After the 4th address is issued, go to LAST.
  - **LAST.** `state`=2'b00. Capture the 4th byte and load `word` <= {`sr`[23:0], `out_mem`}. Set `word_valid`=1, set `word_idx` = word address bits [5:2], and go to WAIT_OUT.
  - **WAIT_OUT.** Hold `word`, `word_idx` and `word_valid`. On `word_valid`&`word_ready`, clear `word_valid`.
    - If the word just accepted contained byte DATA_DEPTH-1, go to DONE.
    - Otherwise go to FETCH.
  - **DONE.** `done`=1. On `start`=1, clear `done`, clear `addr` and go to FETCH.
- `start` is ignored in FETCH, LAST and WAIT_OUT.
- Backpressure: while a word is held, no read is issued. `indirizzo_read` keeps its last value and `state`=2'b00.
- `addr` wraps from DATA_DEPTH-1 to 0. This wrap is never used inside a pass.
- Reset values: all outputs 0 (`indirizzo_read`=0, `state`=2'b00, `word`=0, `word_valid`=0, `word_idx`=0, `last_word`=0, `busy`=0, `done`=0). FSM returns to IDLE; `sr` and `byte_cnt` clear.
- Reset mid-pass: abandon immediately. A held word is dropped without a handshake. The next pass starts only on a new `start` and begins at address 0.

## Timing

- Let `start` be sampled at the edge ending cycle s.
- FETCH issues addresses 4k..4k+3 in cycles s+1..s+4 for the first word.
- LAST occurs in cycle s+5. `word_valid` is high from cycle s+6.
- If `word_ready`=1 in the first valid cycle, the handshake completes at the edge ending that cycle and FETCH resumes the next cycle.
- Minimum period is 6 cycles per word.
- With `word_ready` tied to 1, word n (0-based) is valid in cycle s+6+6n.
- For N = DATA_DEPTH/4 words, `done` rises in cycle s+6N+1. At DATA_DEPTH=512 this is s+769.
- Each stall cycle (`word_ready`=0 while `word_valid`=1) delays all later words by exactly one cycle.
- `busy` falls in the same cycle `done` rises.

## Test plan

- **Reset:** hold `reset`=0 for 2 cycles with `start`=1 -> all outputs 0 and no read issued (`state` stays 2'b00).
- **Full pass:** memory preloaded ram[i]=i[7:0], `word_ready`=1, pulse `start` -> required response:
  - word0 = 0x00010203 with `word_idx`=0;
  - word15 = 0x3C3D3E3F with `last_word`=1;
  - word16 = 0x40414243 with `word_idx`=0;
  - word127 = 0xFCFDFEFF;
  - exactly 128 handshakes;
  - `done` high in cycle s+769.
- **Backpressure:** hold `word_ready`=0 for 10 cycles while word2 is presented -> required response:
  - `word`=0x08090A0B stable and `word_valid` held;
  - `state`=2'b00 and `indirizzo_read` unchanged throughout;
  - after the stall, word3=0x0C0D0E0F;
  - `done` 10 cycles later than in the full-pass case.
- **Start handling:** pulse `start` in cycle s+20 (while busy) -> required response:
  - ignored, sequence unchanged;
  - after `done`, a new `start` clears `done` and the first word is again 0x00010203.
- **Reset mid-pass:** `reset`=0 while word5 is held -> required response:
  - next cycle `word_valid`=0, `busy`=0, `indirizzo_read`=0;
  - after release and `start`, the first word is 0x00010203.
- **Small depth:** `DATA_DEPTH`=64, `ADDR_WIDTH`=6 -> required response: 16 words, `last_word` only on word15, `done` in cycle s+97.
